b_operand_sequencer: RTL and testbench

- Issue-stage controller that sequences production of the ALU B operand.
- Accepts one decoded instruction at a time over a valid/ready handshake.
- Decides whether a register-file read is needed, stalls on the scoreboard, issues the read, and applies the immediate/upper-immediate merge.
- Presents a registered B operand plus tag to the execute stage over a second valid/ready handshake.

---
 rtl/b_operand_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_b_operand_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_operand_sequencer.sv
// ---------------------------------------------------------------------------
// b_operand_sequencer
//
// Issue-stage controller that produces the ALU B operand for one decoded
// instruction at a time. An accepted instruction either resolves directly
// (immediate mode) or reads the register file, waiting on the scoreboard
// first, and optionally merges the upper half of the immediate into the read
// data. The resolved operand and its tag are held in registers and offered to
// the execute stage.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. A producer holding valid keeps its payload stable
// until that edge; ready never depends on valid.
//
// Optional build macro:
//   OPERAND_ZERO_REG_SKIP_EN - register 0 reads as hardwired zero, so an
//                              accept naming it resolves without a read.
//
// Ports:
//   clk, sync_rst    clock, synchronous active-high reset
//   InstrValid/Ready decoded-instruction handshake
//   InstrImmMode     00 reg, 01 imm, 11 upper-imm, 10 same as 00
//   InstrBAddr       B source register
//   InstrImmediate   decoded immediate
//   InstrTag         opaque tag carried to OpTag
//   RegBusy          scoreboard: latched B register has a pending write
//   RegReadEn/Addr   register-file read strobe and address
//   RegReadData      read data, valid the cycle after RegReadEn
//   OpValid/Ready    operand handshake to execute
//   OpBData, OpTag   resolved operand and its tag
//   DbgState         current FSM state (IDLE=0, READ=1, CAPTURE=2, OUT=3)
// ---------------------------------------------------------------------------
module b_operand_sequencer #(
   parameter int DATABITWIDTH    = 16,  // must be even
   parameter int REGADDRBITWIDTH = 4,
   parameter int TAGBITWIDTH     = 4
) (
   input  logic                       clk,
   input  logic                       sync_rst,
   input  logic                       InstrValid,
   output logic                       InstrReady,
   input  logic [1:0]                 InstrImmMode,
   input  logic [REGADDRBITWIDTH-1:0] InstrBAddr,
   input  logic [DATABITWIDTH-1:0]    InstrImmediate,
   input  logic [TAGBITWIDTH-1:0]     InstrTag,
   input  logic                       RegBusy,
   output logic                       RegReadEn,
   output logic [REGADDRBITWIDTH-1:0] RegReadAddr,
   input  logic [DATABITWIDTH-1:0]    RegReadData,
   output logic                       OpValid,
   input  logic                       OpReady,
   output logic [DATABITWIDTH-1:0]    OpBData,
   output logic [TAGBITWIDTH-1:0]     OpTag,
   output logic [1:0]                 DbgState
);

   localparam int HALFWIDTH = DATABITWIDTH / 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ    = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_t;

   state_t state;
   state_t stateNext;

   // Fields of the accepted instruction needed after the accept edge.
   logic                       upperModeQ;
   logic [HALFWIDTH-1:0]       immHiQ;
   logic [TAGBITWIDTH-1:0]     tagQ;
   logic [REGADDRBITWIDTH-1:0] readAddrQ;

   logic                       accept;
   logic                       isImm;
   logic                       isUpper;
   logic                       zeroSkip;
   logic                       directOut;
   logic [DATABITWIDTH-1:0]    directData;
   logic [DATABITWIDTH-1:0]    readResult;

   // ------------------------------------------------------------------------
   // Decode of the offered instruction
   // ------------------------------------------------------------------------
   assign isImm   = (InstrImmMode == 2'b01);
   assign isUpper = (InstrImmMode == 2'b11);

`ifdef OPERAND_ZERO_REG_SKIP_EN
   // Register 0 is constant zero: no read, and the scoreboard is irrelevant.
   assign zeroSkip = ~isImm & (InstrBAddr == '0);
`else
   assign zeroSkip = 1'b0;
`endif

   // Instructions that resolve on the accept edge and go straight to OUT.
   assign directOut = isImm | zeroSkip;

   always_comb begin
      directData = '0;
      if (isImm) begin
         directData = InstrImmediate;
      end else if (isUpper) begin
         // Zero-register upper-immediate: read data contributes zeros.
         directData = {InstrImmediate[DATABITWIDTH-1:HALFWIDTH], {HALFWIDTH{1'b0}}};
      end
   end

   // Mode 10 is folded into register mode simply by only checking for 11.
   assign readResult = upperModeQ ? {immHiQ, RegReadData[HALFWIDTH-1:0]}
                                  : RegReadData;

   // ------------------------------------------------------------------------
   // Handshake outputs
   // ------------------------------------------------------------------------
   // Ready while idle, or while the held operand is being consumed this cycle
   // so a new instruction can follow without a bubble.
   assign InstrReady  = ~sync_rst & ((state == IDLE) | ((state == OUT) & OpReady));
   assign accept      = InstrValid & InstrReady;
   assign RegReadEn   = ~sync_rst & (state == READ) & ~RegBusy;
   assign RegReadAddr = readAddrQ;
   assign OpValid     = ~sync_rst & (state == OUT);
   assign DbgState    = state;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accept) begin
               stateNext = directOut ? OUT : READ;
            end
         end
         READ: begin
            // Stall for as long as the scoreboard reports a pending write.
            if (!RegBusy) begin
               stateNext = CAPTURE;
            end
         end
         CAPTURE: begin
            stateNext = OUT;
         end
         OUT: begin
            if (accept) begin
               stateNext = directOut ? OUT : READ;
            end else if (OpReady) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state      <= IDLE;
         upperModeQ <= 1'b0;
         immHiQ     <= '0;
         tagQ       <= '0;
         readAddrQ  <= '0;
         OpBData    <= '0;
         OpTag      <= '0;
      end else begin
         state <= stateNext;

         if (accept) begin
            upperModeQ <= isUpper;
            immHiQ     <= InstrImmediate[DATABITWIDTH-1:HALFWIDTH];
            tagQ       <= InstrTag;
            if (directOut) begin
               OpBData <= directData;
               OpTag   <= InstrTag;
            end else begin
               // Only updated when a read follows, so the read address
               // keeps its last value through immediate-only traffic.
               readAddrQ <= InstrBAddr;
            end
         end

         // Read data arrives the cycle after the strobe, which is CAPTURE.
         if (state == CAPTURE) begin
            OpBData <= readResult;
            OpTag   <= tagQ;
         end
      end
   end

endmodule

// File: tb/tb_b_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_b_operand_sequencer
//
// Directed scenarios followed by a random phase. Expected operands are
// computed from a small behavioural model of the register file and modes and
// queued when an instruction is accepted; a monitor pops and compares them at
// every operand handshake. Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_b_operand_sequencer;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int TW = 4;
   localparam int EW = TW + DW;

   // ------------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          sync_rst;
   logic          InstrValid;
   logic          InstrReady;
   logic [1:0]    InstrImmMode;
   logic [AW-1:0] InstrBAddr;
   logic [DW-1:0] InstrImmediate;
   logic [TW-1:0] InstrTag;
   logic          RegBusy;
   logic          RegReadEn;
   logic [AW-1:0] RegReadAddr;
   logic [DW-1:0] RegReadData;
   logic          OpValid;
   logic          OpReady;
   logic [DW-1:0] OpBData;
   logic [TW-1:0] OpTag;
   logic [1:0]    DbgState;

   always #5 clk = ~clk;

   b_operand_sequencer #(
      .DATABITWIDTH    (DW),
      .REGADDRBITWIDTH (AW),
      .TAGBITWIDTH     (TW)
   ) dut (
      .clk            (clk),
      .sync_rst       (sync_rst),
      .InstrValid     (InstrValid),
      .InstrReady     (InstrReady),
      .InstrImmMode   (InstrImmMode),
      .InstrBAddr     (InstrBAddr),
      .InstrImmediate (InstrImmediate),
      .InstrTag       (InstrTag),
      .RegBusy        (RegBusy),
      .RegReadEn      (RegReadEn),
      .RegReadAddr    (RegReadAddr),
      .RegReadData    (RegReadData),
      .OpValid        (OpValid),
      .OpReady        (OpReady),
      .OpBData        (OpBData),
      .OpTag          (OpTag),
      .DbgState       (DbgState)
   );

   // ------------------------------------------------------------------------
   // Scoreboard state and checking
   // ------------------------------------------------------------------------
   logic [EW-1:0] expQ[$];
   logic [DW-1:0] regs[16];
   int            nChecks = 0;
   int            nErrors = 0;
   int            strobes = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected {tag, operand} for an instruction accepted now.
   function automatic logic [EW-1:0] model(input logic [1:0] mode, input logic [AW-1:0] addr,
                                           input logic [DW-1:0] imm, input logic [TW-1:0] tag);
      logic [DW-1:0] rd;
      logic [DW-1:0] d;
      rd = regs[addr];
`ifdef OPERAND_ZERO_REG_SKIP_EN
      if (addr == '0) rd = '0;
`endif
      if (mode == 2'b01)      d = imm;
      else if (mode == 2'b11) d = {imm[DW-1:DW/2], rd[DW/2-1:0]};
      else                    d = rd;
      return {tag, d};
   endfunction

   // ------------------------------------------------------------------------
   // Register-file model: data appears the cycle after the strobe, garbage
   // otherwise so a capture on the wrong cycle is visible.
   // ------------------------------------------------------------------------
   initial begin
      logic          pend;
      logic [AW-1:0] pendAddr;
      RegReadData = '0;
      forever begin
         @(negedge clk);
         pend     = RegReadEn;
         pendAddr = RegReadAddr;
         @(posedge clk);
         #1;
         RegReadData = pend ? regs[pendAddr] : DW'($urandom);
      end
   end

   // ------------------------------------------------------------------------
   // Output monitor
   // ------------------------------------------------------------------------
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         if (RegReadEn) begin
            strobes++;
            if (OpValid) check("read_while_opvalid", 32'(OpValid), 32'd0);
         end
         if (!sync_rst && OpValid && OpReady) begin
            if (expQ.size() == 0) begin
               check("unexpected_op", 32'(OpBData), 32'hFFFF_FFFF);
            end else begin
               e = expQ.pop_front();
               check("op_data", 32'(OpBData), 32'(e[DW-1:0]));
               check("op_tag", 32'(OpTag), 32'(e[EW-1:DW]));
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction, hold it until accepted; returns 1 time unit after
   // the accept edge.
   task automatic send(input logic [1:0] mode, input logic [AW-1:0] addr,
                       input logic [DW-1:0] imm, input logic [TW-1:0] tag, input bit pushExp);
      bit seen = 0;
      step();
      InstrValid     = 1'b1;
      InstrImmMode   = mode;
      InstrBAddr     = addr;
      InstrImmediate = imm;
      InstrTag       = tag;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (InstrReady) seen = 1;
         else step();
      end
      if (!seen) check("accept_timeout", 32'd0, 32'd1);
      step();
      if (seen && pushExp) expQ.push_back(model(mode, addr, imm, tag));
      InstrValid = 1'b0;
   endtask

   task automatic waitOp();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (OpValid) seen = 1;
      end
      if (!seen) check("opvalid_timeout", 32'd0, 32'd1);
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int s0;
      int issued;
      bit acc;
      sync_rst = 1'b1;
      InstrValid = 1'b0;
      InstrImmMode = 2'b00;
      InstrBAddr = '0;
      InstrImmediate = '0;
      InstrTag = '0;
      RegBusy = 1'b0;
      OpReady = 1'b1;
      for (int i = 0; i < 16; i++) regs[i] = DW'($urandom);
      regs[0] = 16'h5A5A;
      regs[2] = 16'h12CD;
      regs[5] = 16'hBEEF;
      regs[7] = 16'hC0DE;
      regs[9] = 16'h9999;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_instr_ready", 32'(InstrReady), 32'd0);
      check("rst_op_valid", 32'(OpValid), 32'd0);
      check("rst_read_en", 32'(RegReadEn), 32'd0);
      check("rst_read_addr", 32'(RegReadAddr), 32'd0);
      check("rst_op_data", 32'(OpBData), 32'd0);
      check("rst_op_tag", 32'(OpTag), 32'd0);
      step();
      sync_rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", 32'(InstrReady), 32'd1);
      check("post_rst_state", 32'(DbgState), 32'd0);

      // Immediate mode: one-cycle latency, no read
      s0 = strobes;
      send(2'b01, 4'd0, 16'h1234, 4'd3, 1);
      @(negedge clk);
      check("imm_latency", 32'(OpValid), 32'd1);
      check("imm_no_read", 32'(RegReadEn), 32'd0);
      step();
      @(negedge clk);
      check("imm_opvalid_drop", 32'(OpValid), 32'd0);
      check("imm_strobes", 32'(strobes - s0), 32'd0);

      // Register mode, no stall: strobe at T+1, OpValid at T+3
      s0 = strobes;
      send(2'b00, 4'd5, 16'h0F0F, 4'd5, 1);
      @(negedge clk);
      check("reg_read_en", 32'(RegReadEn), 32'd1);
      check("reg_read_addr", 32'(RegReadAddr), 32'd5);
      step();
      @(negedge clk);
      check("reg_read_one_cycle", 32'(RegReadEn), 32'd0);
      check("reg_not_early", 32'(OpValid), 32'd0);
      step();
      @(negedge clk);
      check("reg_latency", 32'(OpValid), 32'd1);
      step();
      check("reg_strobes", 32'(strobes - s0), 32'd1);

      // Upper-immediate merge
      send(2'b11, 4'd2, 16'hAB00, 4'd9, 1);
      waitOp();
      check("upper_merge", 32'(OpBData), 32'hABCD);
      step();

      // Scoreboard stall for 4 cycles
      RegBusy = 1'b1;
      s0 = strobes;
      send(2'b00, 4'd7, 16'h0000, 4'd2, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_no_read", 32'(RegReadEn), 32'd0);
         check("stall_state", 32'(DbgState), 32'd1);
         step();
      end
      RegBusy = 1'b0;
      @(negedge clk);
      check("stall_strobe", 32'(RegReadEn), 32'd1);
      step();
      @(negedge clk);
      check("stall_not_early", 32'(OpValid), 32'd0);
      step();
      @(negedge clk);
      check("stall_latency", 32'(OpValid), 32'd1);
      step();
      check("stall_strobes", 32'(strobes - s0), 32'd1);

      // Back-pressure then back-to-back accept without a gap
      OpReady = 1'b0;
      send(2'b01, 4'd0, 16'h0055, 4'd6, 1);
      InstrValid = 1'b1;
      InstrImmMode = 2'b01;
      InstrBAddr = 4'd3;
      InstrImmediate = 16'h0042;
      InstrTag = 4'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_instr_ready", 32'(InstrReady), 32'd0);
         check("bp_op_valid", 32'(OpValid), 32'd1);
         check("bp_op_stable", 32'(OpBData), 32'h0055);
         step();
      end
      OpReady = 1'b1;
      @(negedge clk);
      check("bp_ready_on_consume", 32'(InstrReady), 32'd1);
      step();
      expQ.push_back(model(2'b01, 4'd3, 16'h0042, 4'd7));
      InstrValid = 1'b0;
      @(negedge clk);
      check("bp_no_gap", 32'(OpValid), 32'd1);
      check("bp_new_data", 32'(OpBData), 32'h0042);
      step();

      // Reset while in CAPTURE discards the instruction
      send(2'b00, 4'd9, 16'h0000, 4'd4, 0);
      step();
      sync_rst = 1'b1;
      @(negedge clk);
      check("rst_in_capture", 32'(DbgState), 32'd2);
      check("rst_ready_low", 32'(InstrReady), 32'd0);
      step();
      sync_rst = 1'b0;
      @(negedge clk);
      check("rst_discard_valid", 32'(OpValid), 32'd0);
      check("rst_discard_state", 32'(DbgState), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_operand", 32'(OpValid), 32'd0);
      end
      step();

      // Register 0 with upper-immediate
      s0 = strobes;
      send(2'b11, 4'd0, 16'h7F00, 4'hA, 1);
      @(negedge clk);
`ifdef OPERAND_ZERO_REG_SKIP_EN
      check("zero_skip_latency", 32'(OpValid), 32'd1);
      check("zero_skip_data", 32'(OpBData), 32'h7F00);
`else
      check("zero_reads_state", 32'(DbgState), 32'd1);
`endif
      waitOp();
      step();
`ifdef OPERAND_ZERO_REG_SKIP_EN
      check("zero_skip_strobes", 32'(strobes - s0), 32'd0);
`else
      check("zero_reads_strobes", 32'(strobes - s0), 32'd1);
`endif

      // Random phase: random modes, addresses, stalls and back-pressure
      issued = 0;
      for (int c = 0; c < 2000 && (issued < 30 || InstrValid); c++) begin
         OpReady = ($urandom_range(0, 3) != 0);
         RegBusy = ($urandom_range(0, 3) == 0);
         if (!InstrValid && issued < 30 && $urandom_range(0, 1) == 1) begin
            InstrValid     = 1'b1;
            InstrImmMode   = 2'($urandom_range(0, 3));
            InstrBAddr     = AW'($urandom_range(0, 15));
            InstrImmediate = DW'($urandom);
            InstrTag       = TW'($urandom);
         end
         @(negedge clk);
         acc = InstrValid && InstrReady;
         step();
         if (acc) begin
            expQ.push_back(model(InstrImmMode, InstrBAddr, InstrImmediate, InstrTag));
            InstrValid = 1'b0;
            issued++;
         end
      end
      check("random_issued", 32'(issued), 32'd30);
      InstrValid = 1'b0;
      OpReady = 1'b1;
      RegBusy = 1'b0;

      // Drain
      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(negedge clk);
      check("drain_empty", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
